mem_bus_sequencer: RTL and testbench
====================================

# mem_bus_sequencer

Executes the single memory transaction granted by the memory arbiter. It watches the three one-hot grant lines (`rom_garant`, `ram_garant_rd`, `ram_garant_wr`), latches the winning requester's address and data, drives the ROM/RAM enables for a configurable number of wait states, and returns read data plus a one-cycle done pulse to the requester. It sits directly downstream of the arbiter, between it and the ROM/RAM macros.

## Interface
Parameters:
- `ADDR_W`, 8: address width for both ROM and RAM.
- `DATA_W`, 8: data width.
- `ROM_WAIT`, 1: extra ROM access cycles, range 0..15.
- `RAM_WAIT`, 2: extra RAM access cycles, range 0..15. Used for both reads and writes.

Ports (clock and reset first):
- `clk` in 1: single clock. Sampled on the rising edge; the arbiter updates grants on the falling edge.
- `reset` in 1: asynchronous, active-high.
- `rom_garant`, `ram_garant_rd`, `ram_garant_wr` in 1 each: grants from the arbiter.
- `rom_addr` in ADDR_W: ROM fetch address from the requester.
- `ram_rd_addr` in ADDR_W: RAM read address from the requester.
- `ram_wr_addr` in ADDR_W: RAM write address from the requester.
- `ram_wr_data` in DATA_W: RAM write data from the requester.
- `rom_q`, `ram_q` in DATA_W: synchronous-read memory outputs.
- `rom_en` out 1, `rom_a` out ADDR_W: ROM enable and address.
- `ram_re` out 1, `ram_we` out 1: RAM read and write enables.
- `ram_a` out ADDR_W, `ram_d` out DATA_W: RAM address and write data.
- `rom_data` out DATA_W, `rom_done` out 1: fetch result and fetch-complete pulse.
- `ram_rd_data` out DATA_W, `ram_rd_done` out 1: read result and read-complete pulse.
- `ram_wr_done` out 1: write-complete pulse.
- `err` out 1: present only with `MEM_SEQ_ERR_EN`.

## Operation
- States: IDLE, ACCESS, RELEASE. 2-bit `kind` register: none, ROM, RD or WR. 4-bit wait counter `cnt`.
- **IDLE**
  - On any grant high, select `kind` by priority ROM > RD > WR, matching the arbiter.
  - Latch the matching address into `rom_a` or `ram_a`. For WR, also latch `ram_wr_data` into `ram_d`.
  - Load `cnt` with `ROM_WAIT` or `RAM_WAIT`.
  - Set the matching enable (`rom_en`, `ram_re` or `ram_we`) and go to ACCESS.
- **ACCESS**
  - Abort check first: if the grant matching `kind` is low, clear the enables, go to IDLE and issue no done pulse. A write may already have been committed by the RAM.
  - Otherwise, if `cnt` = 0:
    - Clear the enables.
    - ROM: capture `rom_q` into `rom_data`. RD: capture `ram_q` into `ram_rd_data`.
    - Assert the matching done pulse and go to RELEASE.
  - Otherwise decrement `cnt`.
- **RELEASE**
  - Clear the done pulse on the first edge.
  - Stay until the grant matching `kind` is low, then go to IDLE.
  - A grant held high never produces a second transaction or a second done pulse.
- Address and data outputs hold their last latched value between transactions.
- `rom_data` and `ram_rd_data` hold until the next completed transaction of the same kind.
- Reset is asynchronous and may hit any state. It forces IDLE, clears `kind` and `cnt`, and drives every output to 0, including `err` and the data registers. Any in-flight transaction is dropped with no done pulse.

## Timing
- Let E0 be the rising edge that sees a grant in IDLE.
- Enables are registered high from E0 and stay high for WAIT+1 cycles. They fall at edge E0+WAIT+1.
- Read data is captured and the done pulse rises at edge E0+WAIT+1.
- The done pulse lasts exactly one cycle and falls at E0+WAIT+2.
- Minimum spacing between back-to-back transactions: WAIT+3 cycles, given an immediate grant drop and a re-grant.
- With WAIT = 0, enables are high for exactly one cycle.
- At most one enable and at most one done output is high at any time.
- A grant arriving on the same edge that RELEASE returns to IDLE is not serviced until the next edge.

## Configuration
- `MEM_SEQ_ERR_EN` defined: adds output `err`, a sticky flag cleared only by `reset`. It sets on either event:
  - more than one grant high in IDLE;
  - an abort in ACCESS.
- `MEM_SEQ_ERR_EN` undefined: the `err` port and its logic are absent.
- Functional behaviour is identical in both cases; priority and abort handling do not change.

## Test plan
- **ROM fetch.** `ROM_WAIT`=1, `rom_addr`=0x3C, `rom_q`=0xA5, `rom_garant` high.
  -> `rom_en` high 2 cycles with `rom_a`=0x3C; `rom_done` pulses once; `rom_data`=0xA5.
- **RAM write then read.** `RAM_WAIT`=2, write addr 0x10 data 0x5A, grant dropped after done; then read addr 0x10 with `ram_q`=0x5A.
  -> `ram_we` high 3 cycles with `ram_a`=0x10 and `ram_d`=0x5A; one `ram_wr_done` pulse; then `ram_rd_data`=0x5A and one `ram_rd_done` pulse.
- **Held grant.** `ram_garant_rd` held high for 20 cycles.
  -> exactly one `ram_re` burst and one `ram_rd_done` pulse.
- **Multiple grants.** `rom_garant` and `ram_garant_wr` high together in IDLE.
  -> ROM serviced; `ram_we` stays 0; `err`=1 with the macro.
- **Abort.** `ram_garant_rd` dropped while `cnt`=1.
  -> `ram_re` falls next edge; no `ram_rd_done`; state IDLE; `err`=1 with the macro.
- **Reset mid-access.** `reset` pulsed mid-ACCESS, not aligned to `clk`.
  -> all outputs 0 immediately; after release, a new grant gives normal latency.

Source files
------------

// File: rtl/mem_bus_sequencer_if.sv
// mem_bus_sequencer_if: arbiter grants, requester payloads and ROM/RAM bus of the sequencer.
// MEM_SEQ_ERR_EN adds the sticky err output.
interface mem_bus_sequencer_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
    logic              rom_garant, ram_garant_rd, ram_garant_wr;
    logic [ADDR_W-1:0] rom_addr, ram_rd_addr, ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data, rom_q, ram_q;
    logic              rom_en, ram_re, ram_we;
    logic [ADDR_W-1:0] rom_a, ram_a;
    logic [DATA_W-1:0] ram_d, rom_data, ram_rd_data;
    logic              rom_done, ram_rd_done, ram_wr_done;
`ifdef MEM_SEQ_ERR_EN
    logic              err;
    modport master (
        input  rom_garant, ram_garant_rd, ram_garant_wr, rom_addr, ram_rd_addr, ram_wr_addr,
               ram_wr_data, rom_q, ram_q,
        output rom_en, ram_re, ram_we, rom_a, ram_a, ram_d, rom_data, ram_rd_data,
               rom_done, ram_rd_done, ram_wr_done, err
    );
    modport slave (
        output rom_garant, ram_garant_rd, ram_garant_wr, rom_addr, ram_rd_addr, ram_wr_addr,
               ram_wr_data, rom_q, ram_q,
        input  rom_en, ram_re, ram_we, rom_a, ram_a, ram_d, rom_data, ram_rd_data,
               rom_done, ram_rd_done, ram_wr_done, err
    );
`else
    modport master (
        input  rom_garant, ram_garant_rd, ram_garant_wr, rom_addr, ram_rd_addr, ram_wr_addr,
               ram_wr_data, rom_q, ram_q,
        output rom_en, ram_re, ram_we, rom_a, ram_a, ram_d, rom_data, ram_rd_data,
               rom_done, ram_rd_done, ram_wr_done
    );
    modport slave (
        output rom_garant, ram_garant_rd, ram_garant_wr, rom_addr, ram_rd_addr, ram_wr_addr,
               ram_wr_data, rom_q, ram_q,
        input  rom_en, ram_re, ram_we, rom_a, ram_a, ram_d, rom_data, ram_rd_data,
               rom_done, ram_rd_done, ram_wr_done
    );
`endif
endinterface

// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer: runs the one granted ROM fetch / RAM read / RAM write with wait states.
// MEM_SEQ_ERR_EN adds a sticky err flag for multi-grant and abort events.
module mem_bus_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 2
) (
    input logic clk,
    input logic reset,
    mem_bus_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
    typedef enum logic [1:0] {K_NONE, K_ROM, K_RD, K_WR} kind_t;

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rom_en_q, rom_en_d, ram_re_q, ram_re_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] rom_a_q, rom_a_d, ram_a_q, ram_a_d;
    logic [DATA_W-1:0] ram_d_q, ram_d_d, rom_data_q, rom_data_d, ram_rd_data_q, ram_rd_data_d;
    logic              rom_done_q, rom_done_d, ram_rd_done_q, ram_rd_done_d;
    logic              ram_wr_done_q, ram_wr_done_d;
    logic              any_gnt, multi_gnt, gnt_k;
`ifdef MEM_SEQ_ERR_EN
    logic              err_q, err_d;
`endif

    assign any_gnt   = bus.rom_garant | bus.ram_garant_rd | bus.ram_garant_wr;
    assign multi_gnt = (bus.rom_garant & bus.ram_garant_rd) | (bus.rom_garant & bus.ram_garant_wr)
                     | (bus.ram_garant_rd & bus.ram_garant_wr);
    assign gnt_k     = kind_q == K_ROM ? bus.rom_garant :
                       kind_q == K_RD  ? bus.ram_garant_rd :
                       kind_q == K_WR  ? bus.ram_garant_wr : 1'b0;

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        cnt_d         = cnt_q;
        rom_en_d      = rom_en_q;
        ram_re_d      = ram_re_q;
        ram_we_d      = ram_we_q;
        rom_a_d       = rom_a_q;
        ram_a_d       = ram_a_q;
        ram_d_d       = ram_d_q;
        rom_data_d    = rom_data_q;
        ram_rd_data_d = ram_rd_data_q;
        rom_done_d    = 1'b0;
        ram_rd_done_d = 1'b0;
        ram_wr_done_d = 1'b0;
`ifdef MEM_SEQ_ERR_EN
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: if (any_gnt) begin
                state_d = ACCESS;
`ifdef MEM_SEQ_ERR_EN
                err_d   = err_q | multi_gnt;
`endif
                if (bus.rom_garant) begin
                    kind_d   = K_ROM;
                    rom_a_d  = bus.rom_addr;
                    cnt_d    = 4'(ROM_WAIT);
                    rom_en_d = 1'b1;
                end else if (bus.ram_garant_rd) begin
                    kind_d   = K_RD;
                    ram_a_d  = bus.ram_rd_addr;
                    cnt_d    = 4'(RAM_WAIT);
                    ram_re_d = 1'b1;
                end else begin
                    kind_d   = K_WR;
                    ram_a_d  = bus.ram_wr_addr;
                    ram_d_d  = bus.ram_wr_data;
                    cnt_d    = 4'(RAM_WAIT);
                    ram_we_d = 1'b1;
                end
            end
            ACCESS: if (!gnt_k) begin
                // abort: the RAM may already hold a partial write, but nobody is told done
                state_d  = IDLE;
                rom_en_d = 1'b0;
                ram_re_d = 1'b0;
                ram_we_d = 1'b0;
`ifdef MEM_SEQ_ERR_EN
                err_d    = 1'b1;
`endif
            end else if (cnt_q == 4'd0) begin
                state_d       = RELEASE;
                rom_en_d      = 1'b0;
                ram_re_d      = 1'b0;
                ram_we_d      = 1'b0;
                rom_data_d    = kind_q == K_ROM ? bus.rom_q : rom_data_q;
                ram_rd_data_d = kind_q == K_RD ? bus.ram_q : ram_rd_data_q;
                rom_done_d    = kind_q == K_ROM;
                ram_rd_done_d = kind_q == K_RD;
                ram_wr_done_d = kind_q == K_WR;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RELEASE: state_d = gnt_k ? RELEASE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            kind_q        <= K_NONE;
            cnt_q         <= '0;
            rom_en_q      <= 1'b0;
            ram_re_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            rom_a_q       <= '0;
            ram_a_q       <= '0;
            ram_d_q       <= '0;
            rom_data_q    <= '0;
            ram_rd_data_q <= '0;
            rom_done_q    <= 1'b0;
            ram_rd_done_q <= 1'b0;
            ram_wr_done_q <= 1'b0;
`ifdef MEM_SEQ_ERR_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            cnt_q         <= cnt_d;
            rom_en_q      <= rom_en_d;
            ram_re_q      <= ram_re_d;
            ram_we_q      <= ram_we_d;
            rom_a_q       <= rom_a_d;
            ram_a_q       <= ram_a_d;
            ram_d_q       <= ram_d_d;
            rom_data_q    <= rom_data_d;
            ram_rd_data_q <= ram_rd_data_d;
            rom_done_q    <= rom_done_d;
            ram_rd_done_q <= ram_rd_done_d;
            ram_wr_done_q <= ram_wr_done_d;
`ifdef MEM_SEQ_ERR_EN
            err_q         <= err_d;
`endif
        end
    end

    assign bus.rom_en      = rom_en_q;
    assign bus.ram_re      = ram_re_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.rom_a       = rom_a_q;
    assign bus.ram_a       = ram_a_q;
    assign bus.ram_d       = ram_d_q;
    assign bus.rom_data    = rom_data_q;
    assign bus.ram_rd_data = ram_rd_data_q;
    assign bus.rom_done    = rom_done_q;
    assign bus.ram_rd_done = ram_rd_done_q;
    assign bus.ram_wr_done = ram_wr_done_q;
`ifdef MEM_SEQ_ERR_EN
    assign bus.err         = err_q;
`endif
endmodule

// File: tb/tb_mem_bus_sequencer.sv
// tb_mem_bus_sequencer: directed checks of fetch, write/read, held grant, abort, reset, multi-grant.
// Build with MEM_SEQ_ERR_EN to also check err.
module tb_mem_bus_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int n_rom_en, n_re, n_we, n_rom_done, n_rd_done, n_wr_done;

    mem_bus_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    mem_bus_sequencer #(.ADDR_W(8), .DATA_W(8), .ROM_WAIT(1), .RAM_WAIT(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        bus.rom_garant    = 1'b0;
        bus.ram_garant_rd = 1'b0;
        bus.ram_garant_wr = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, {29'd0, bus.rom_en, bus.ram_re, bus.ram_we}, 0);
        chk({tag, "_done"}, {29'd0, bus.rom_done, bus.ram_rd_done, bus.ram_wr_done}, 0);
        chk({tag, "_addr"}, {16'd0, bus.rom_a, bus.ram_a}, 0);
        chk({tag, "_data"}, {8'd0, bus.ram_d, bus.rom_data, bus.ram_rd_data}, 0);
`ifdef MEM_SEQ_ERR_EN
        chk({tag, "_err"}, {31'd0, bus.err}, 0);
`endif
    endtask

    // Run n cycles tallying enables/dones; optionally drop all grants once a done is seen.
    task automatic window(input int n, input bit drop_on_done);
        n_rom_en = 0; n_re = 0; n_we = 0; n_rom_done = 0; n_rd_done = 0; n_wr_done = 0;
        for (int i = 0; i < n; i++) begin
            step();
            n_rom_en   += int'(bus.rom_en);
            n_re       += int'(bus.ram_re);
            n_we       += int'(bus.ram_we);
            n_rom_done += int'(bus.rom_done);
            n_rd_done  += int'(bus.ram_rd_done);
            n_wr_done  += int'(bus.ram_wr_done);
            chk("onehot_en", {31'd0, (int'(bus.rom_en) + int'(bus.ram_re) + int'(bus.ram_we)) > 1}, 0);
            chk("onehot_done", {31'd0, (int'(bus.rom_done) + int'(bus.ram_rd_done) + int'(bus.ram_wr_done)) > 1}, 0);
            if (drop_on_done && (bus.rom_done || bus.ram_rd_done || bus.ram_wr_done)) drop();
        end
    endtask

    initial begin
        drop();
        bus.rom_addr = '0; bus.ram_rd_addr = '0; bus.ram_wr_addr = '0;
        bus.ram_wr_data = '0; bus.rom_q = '0; bus.ram_q = '0;
        #2;
        chk_zero("reset");
        step();
        step();
        reset = 1'b0;
        step();
        chk_zero("idle");

        bus.rom_addr = 8'h3C; bus.rom_q = 8'hA5; bus.rom_garant = 1'b1;
        step();
        chk("rom_e0_en", {31'd0, bus.rom_en}, 1);
        chk("rom_e0_a", {24'd0, bus.rom_a}, 32'h3C);
        step();
        chk("rom_e1_en", {31'd0, bus.rom_en}, 1);
        chk("rom_e1_done", {31'd0, bus.rom_done}, 0);
        step();
        chk("rom_e2_en", {31'd0, bus.rom_en}, 0);
        chk("rom_e2_done", {31'd0, bus.rom_done}, 1);
        chk("rom_data", {24'd0, bus.rom_data}, 32'hA5);
        drop();
        step();
        chk("rom_e3_done", {31'd0, bus.rom_done}, 0);
        window(4, 0);
        chk("rom_after_en", n_rom_en, 0);

        bus.ram_wr_addr = 8'h10; bus.ram_wr_data = 8'h5A; bus.ram_garant_wr = 1'b1;
        window(8, 1);
        chk("wr_we_cycles", n_we, 3);
        chk("wr_done_pulses", n_wr_done, 1);
        chk("wr_ram_a", {24'd0, bus.ram_a}, 32'h10);
        chk("wr_ram_d", {24'd0, bus.ram_d}, 32'h5A);

        bus.ram_rd_addr = 8'h10; bus.ram_q = 8'h5A; bus.ram_garant_rd = 1'b1;
        window(8, 1);
        chk("rd_re_cycles", n_re, 3);
        chk("rd_done_pulses", n_rd_done, 1);
        chk("rd_data", {24'd0, bus.ram_rd_data}, 32'h5A);
        chk("rd_ram_d_held", {24'd0, bus.ram_d}, 32'h5A);
        chk("rd_rom_data_held", {24'd0, bus.rom_data}, 32'hA5);

        bus.ram_rd_addr = 8'h22; bus.ram_q = 8'h77; bus.ram_garant_rd = 1'b1;
        window(20, 0);
        chk("held_re_cycles", n_re, 3);
        chk("held_done_pulses", n_rd_done, 1);
        chk("held_rd_data", {24'd0, bus.ram_rd_data}, 32'h77);
        drop();
        step();
        chk("held_state_idle", {30'd0, dut.state_q}, 0);
`ifdef MEM_SEQ_ERR_EN
        chk("err_clear_before_abort", {31'd0, bus.err}, 0);
`endif

        bus.ram_rd_addr = 8'h20; bus.ram_q = 8'h11; bus.ram_garant_rd = 1'b1;
        step();
        chk("abort_e0_re", {31'd0, bus.ram_re}, 1);
        step();
        chk("abort_e1_re", {31'd0, bus.ram_re}, 1);
        drop();
        step();
        chk("abort_re_fall", {31'd0, bus.ram_re}, 0);
        chk("abort_no_done", {31'd0, bus.ram_rd_done}, 0);
        chk("abort_state_idle", {30'd0, dut.state_q}, 0);
`ifdef MEM_SEQ_ERR_EN
        chk("abort_err", {31'd0, bus.err}, 1);
`endif
        window(4, 0);
        chk("abort_late_done", n_rd_done, 0);
        chk("abort_rd_data_held", {24'd0, bus.ram_rd_data}, 32'h77);

        bus.ram_wr_addr = 8'h33; bus.ram_wr_data = 8'h99; bus.ram_garant_wr = 1'b1;
        step();
        chk("rst_pre_we", {31'd0, bus.ram_we}, 1);
        #2 reset = 1'b1;
        #1;
        chk_zero("rst_mid");
        chk("rst_state_idle", {30'd0, dut.state_q}, 0);
        #2 reset = 1'b0;
        window(8, 1);
        chk("rst_after_we_cycles", n_we, 3);
        chk("rst_after_done", n_wr_done, 1);
        chk("rst_after_ram_a", {24'd0, bus.ram_a}, 32'h33);
        chk("rst_after_ram_d", {24'd0, bus.ram_d}, 32'h99);

        bus.rom_addr = 8'h44; bus.rom_q = 8'hC3; bus.ram_wr_addr = 8'h55;
        bus.rom_garant = 1'b1; bus.ram_garant_wr = 1'b1;
        window(8, 1);
        chk("multi_rom_en", n_rom_en, 2);
        chk("multi_we", n_we, 0);
        chk("multi_rom_done", n_rom_done, 1);
        chk("multi_wr_done", n_wr_done, 0);
        chk("multi_rom_data", {24'd0, bus.rom_data}, 32'hC3);
        chk("multi_ram_a_held", {24'd0, bus.ram_a}, 32'h33);
`ifdef MEM_SEQ_ERR_EN
        chk("multi_err", {31'd0, bus.err}, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
